// File: rtl/dmem_responder_if.sv
// Load/store channel between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-masked stores, one outstanding request and
// a fixed number of wait states before the response is offered.
module dmem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 RN_N,
    dmem_responder_if.slave      bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cap_data_q, cap_data_d;
    logic        cap_err_q, cap_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_q [DEPTH];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign in_range      = bus.req_addr < ADDR_W'(DEPTH);
    assign idx           = bus.req_addr[IDX_W-1:0];
    assign bus.req_ready = (state_q == S_IDLE) && RN_N;
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // WAIT always runs LATENCY+1 cycles (counter loaded with LATENCY) so the
    // response register rises LATENCY+1 edges after acceptance, including LATENCY=0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_data_d  = cap_data_q;
        cap_err_d   = cap_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cap_err_d  = !in_range;
                    cap_data_d = (!bus.req_we && in_range) ? mem_q[idx] : '0;
                    cnt_d      = 4'(LATENCY);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cap_data_q;
                    rsp_err_d   = cap_err_q;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RN_N) begin
        if (!RN_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_data_q  <= '0;
            cap_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_data_q  <= cap_data_d;
            cap_err_q   <= cap_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or negedge RN_N) begin
        if (!RN_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && bus.req_we && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.req_be[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance checked
// against a word-array memory model and edge-count timing expectations.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rn_n;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) bus2 ();
    dmem_responder_if #(.ADDR_W(32)) bus0 ();

    dmem_responder #(.DEPTH(32), .ADDR_W(32), .LATENCY(2)) u_dut2 (
        .clk(clk), .RN_N(rn_n), .bus(bus2)
    );
    dmem_responder #(.DEPTH(32), .ADDR_W(32), .LATENCY(0)) u_dut0 (
        .clk(clk), .RN_N(rn_n), .bus(bus0)
    );

    int n_cmp;
    int n_err;
    logic [31:0] model2 [32];
    logic [31:0] model0 [32];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++)
            if (be[b]) mask = mask | (32'hFF << (8 * b));
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic void clear_models();
        for (int i = 0; i < 32; i++) begin
            model2[i] = '0;
            model0[i] = '0;
        end
    endfunction

    // Drives one request on the LATENCY=2 instance with rsp_ready high throughout.
    task automatic txn2(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output logic vafter);
        int t;
        bit acc;
        bus2.req_we = we; bus2.req_addr = addr; bus2.req_be = be; bus2.req_wdata = wd;
        bus2.req_valid = 1'b1; bus2.rsp_ready = 1'b1;
        acc = 0; t = 0;
        while (!acc && t < 20) begin
            acc = bus2.req_ready;
            tick();
            t++;
        end
        bus2.req_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: addr=%h never accepted", addr);
            rd = '0; err = 1'b0; lat = -1; vafter = 1'b1;
            return;
        end
        if (we && addr < 32) model2[addr[4:0]] = merge(model2[addr[4:0]], be, wd);
        lat = 0;
        while (!bus2.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        rd = bus2.rsp_rdata;
        err = bus2.rsp_err;
        tick();
        vafter = bus2.rsp_valid;
    endtask

    task automatic test_reset();
        rn_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus2.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", bus2.req_ready); end
        n_cmp++; if (bus2.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus2.rsp_valid); end
        n_cmp++; if (bus2.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rsp_rdata: got %h want 0", bus2.rsp_rdata); end
        n_cmp++; if (bus2.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", bus2.rsp_err); end
        n_cmp++; if (bus0.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready0: got %b want 0", bus0.req_ready); end
        rn_n = 1'b1;
        #1;
        n_cmp++; if (bus2.req_ready !== 1'b1) begin n_err++; $display("FAIL release_req_ready: got %b want 1", bus2.req_ready); end
        tick();
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic err; int lat; logic va;
        txn2(1'b1, 32'd3, 4'hF, 32'hDEADBEEF, rd, err, lat, va);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL store_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL store_rdata: got %h want 0", rd); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL store_err: got %b want 0", err); end
        n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL store_rsp_drop: got %b want 0", va); end
        txn2(1'b0, 32'd3, 4'h0, 32'h0, rd, err, lat, va);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_full_word: got %h want deadbeef", rd); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL load_latency: got %0d want 3", lat); end
        txn2(1'b1, 32'd3, 4'b0010, 32'h0000AA00, rd, err, lat, va);
        txn2(1'b0, 32'd3, 4'h0, 32'h0, rd, err, lat, va);
        n_cmp++; if (rd !== 32'hDEADAAEF) begin n_err++; $display("FAIL byte_merge: got %h want deadaaef", rd); end
        txn2(1'b1, 32'd3, 4'b0000, 32'h12345678, rd, err, lat, va);
        n_cmp++; if (err !== 1'b0 || lat !== 3) begin n_err++; $display("FAIL zero_be_rsp: err=%b lat=%0d want err=0 lat=3", err, lat); end
        txn2(1'b0, 32'd3, 4'h0, 32'h0, rd, err, lat, va);
        n_cmp++; if (rd !== 32'hDEADAAEF) begin n_err++; $display("FAIL zero_be_unchanged: got %h want deadaaef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; logic va;
        logic [31:0] bad [4];
        bad[0] = 32'd32; bad[1] = 32'hFFFFFFFF; bad[2] = 32'h0000_0100; bad[3] = 32'h8000_0003;
        for (int i = 0; i < 4; i++) begin
            txn2(i[0], bad[i], 4'hF, 32'hCAFEF00D, rd, err, lat, va);
            n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL oor_err addr=%h: got %b want 1", bad[i], err); end
            n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_rdata addr=%h: got %h want 0", bad[i], rd); end
        end
        for (int a = 0; a < 32; a++) begin
            txn2(1'b0, 32'(a), 4'h0, 32'h0, rd, err, lat, va);
            n_cmp++; if (rd !== model2[a] || err !== 1'b0) begin n_err++; $display("FAIL oor_no_write addr=%0d: got %h/%b want %h/0", a, rd, err, model2[a]); end
        end
    endtask

    task automatic test_backpressure();
        int t; bit acc; int lat;
        logic [31:0] rd0; logic err0; logic [31:0] st_wd;
        bit stable, rdy_low;
        st_wd = $urandom;
        bus2.req_we = 1'b0; bus2.req_addr = 32'd3; bus2.req_be = 4'h0; bus2.req_wdata = '0;
        bus2.req_valid = 1'b1; bus2.rsp_ready = 1'b0;
        acc = 0; t = 0;
        while (!acc && t < 20) begin acc = bus2.req_ready; tick(); t++; end
        bus2.req_we = 1'b1; bus2.req_addr = 32'd7; bus2.req_be = 4'hF; bus2.req_wdata = st_wd;
        lat = 0;
        while (!bus2.rsp_valid && lat < 40) begin tick(); lat++; end
        rd0 = bus2.rsp_rdata; err0 = bus2.rsp_err;
        n_cmp++; if (rd0 !== model2[3] || err0 !== 1'b0) begin n_err++; $display("FAIL bp_rsp: got %h/%b want %h/0", rd0, err0, model2[3]); end
        stable = 1; rdy_low = 1;
        repeat (5) begin
            tick();
            if (bus2.rsp_valid !== 1'b1 || bus2.rsp_rdata !== rd0 || bus2.rsp_err !== err0) stable = 0;
            if (bus2.req_ready !== 1'b0) rdy_low = 0;
        end
        n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_hold: valid=%b rdata=%h want 1/%h", bus2.rsp_valid, bus2.rsp_rdata, rd0); end
        n_cmp++; if (!rdy_low) begin n_err++; $display("FAIL bp_req_ready: got high want low during response"); end
        bus2.rsp_ready = 1'b1;
        tick();
        n_cmp++; if (bus2.rsp_valid !== 1'b0 || bus2.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL bp_handshake: valid=%b rdata=%h want 0/0", bus2.rsp_valid, bus2.rsp_rdata); end
        n_cmp++; if (bus2.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready: got %b want 1", bus2.req_ready); end
        tick();
        bus2.req_valid = 1'b0;
        n_cmp++; if (bus2.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_pending_accept: req_ready=%b want 0", bus2.req_ready); end
        model2[7] = st_wd;
        lat = 0;
        while (!bus2.rsp_valid && lat < 40) begin tick(); lat++; end
        n_cmp++; if (lat !== 3 || bus2.rsp_err !== 1'b0) begin n_err++; $display("FAIL bp_second_rsp: lat=%0d err=%b want 3/0", lat, bus2.rsp_err); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int lat; logic va;
        logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;
        logic [31:0] exp_rd; logic exp_err;
        repeat (40) begin
            int unsigned sel;
            we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            addr = (sel == 0) ? $urandom : (sel == 1) ? 32 + $urandom_range(0, 7) : $urandom_range(0, 31);
            be = 4'($urandom); wd = $urandom;
            exp_err = (addr >= 32);
            exp_rd = (!we && !exp_err) ? model2[addr[4:0]] : 32'h0;
            txn2(we, addr, be, wd, rd, err, lat, va);
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rand_rdata we=%b addr=%h: got %h want %h", we, addr, rd, exp_rd); end
            n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL rand_err addr=%h: got %b want %b", addr, err, exp_err); end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rand_latency: got %0d want 3", lat); end
            n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL rand_rsp_drop: got %b want 0", va); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int t; bit acc; bit quiet;
        logic [31:0] rd; logic err; int lat; logic va;
        bus2.req_we = 1'b1; bus2.req_addr = 32'd5; bus2.req_be = 4'hF; bus2.req_wdata = 32'h12345678;
        bus2.req_valid = 1'b1; bus2.rsp_ready = 1'b1;
        acc = 0; t = 0;
        while (!acc && t < 20) begin acc = bus2.req_ready; tick(); t++; end
        bus2.req_valid = 1'b0;
        tick();
        rn_n = 1'b0;
        #1;
        clear_models();
        n_cmp++; if (bus2.rsp_valid !== 1'b0 || bus2.rsp_rdata !== 32'h0 || bus2.rsp_err !== 1'b0) begin n_err++; $display("FAIL midreset_outputs: %b/%h/%b want 0/0/0", bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err); end
        n_cmp++; if (bus2.req_ready !== 1'b0) begin n_err++; $display("FAIL midreset_req_ready: got %b want 0", bus2.req_ready); end
        repeat (2) tick();
        rn_n = 1'b1;
        quiet = 1;
        repeat (6) begin tick(); if (bus2.rsp_valid !== 1'b0) quiet = 0; end
        n_cmp++; if (!quiet) begin n_err++; $display("FAIL midreset_dropped: response issued after reset, want none"); end
        txn2(1'b0, 32'd5, 4'h0, 32'h0, rd, err, lat, va);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midreset_mem5: got %h want 0", rd); end
        txn2(1'b0, 32'd7, 4'h0, 32'h0, rd, err, lat, va);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midreset_mem7: got %h want 0", rd); end
    endtask

    task automatic test_lat0_back_to_back();
        int t; bit acc; int lat;
        logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;
        logic [31:0] exp_rd;
        bus0.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i[0] == 1'b0) begin
                we = 1'b1; addr = $urandom_range(0, 31); be = 4'($urandom); wd = $urandom;
            end else begin
                we = 1'b0;
            end
            bus0.req_we = we; bus0.req_addr = addr; bus0.req_be = be; bus0.req_wdata = wd;
            bus0.req_valid = 1'b1;
            exp_rd = we ? 32'h0 : model0[addr[4:0]];
            acc = 0; t = 0;
            while (!acc && t < 20) begin acc = bus0.req_ready; tick(); t++; end
            if (we) model0[addr[4:0]] = merge(model0[addr[4:0]], be, wd);
            if (i > 0) begin
                n_cmp++; if (t !== 1) begin n_err++; $display("FAIL lat0_accept_gap req=%0d: got %0d edges want 1 after handshake", i, t); end
            end
            lat = 0;
            while (!bus0.rsp_valid && lat < 40) begin tick(); lat++; end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL lat0_latency req=%0d: got %0d want 1", i, lat); end
            n_cmp++; if (bus0.rsp_rdata !== exp_rd || bus0.rsp_err !== 1'b0) begin n_err++; $display("FAIL lat0_rsp req=%0d: got %h/%b want %h/0", i, bus0.rsp_rdata, bus0.rsp_err, exp_rd); end
            tick();
        end
        bus0.req_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rn_n = 1'b0;
        clear_models();
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_be = '0;
        bus2.req_wdata = '0; bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_be = '0;
        bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_lat0_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
